sprite_depth_scaler: RTL and testbench
======================================

// Module: sprite_depth_scaler
// PURPOSE
//  Parametrised depth-scaled sprite renderer for the VGA path (ball, paddle markers).
//  Maps z depth to one of NUM_ZONES pre-scaled bitmaps held in one shared ROM.
//  Issues ROM addresses in raster order and returns a pipelined pixel colour with a transparency flag.
//  Adds per-frame position latching, colour-key transparency and horizontal mirroring.
// PARAMETERS
//  NUM_ZONES    10      number of depth zones/bitmaps
//  ZONE_DEPTH   100     z units per zone; zone = min(z_loc/ZONE_DEPTH, NUM_ZONES-1)
//  ADDR_W       14      ROM address width (default tables total 14885 words)
//  COLOR_W      24      pixel width
//  ROM_LATENCY  1       ROM read latency in clocks (>=1)
//  TRANSP_KEY   24'h0   rom_data value rendered as transparent
// PORTS
//  clk          in   1        pixel clock
//  rst_n        in   1        async active-low reset
//  frame_start  in   1        1-cycle pulse before first pixel of a frame
//  x_loc        in   16       sprite left column (sampled on frame_start)
//  y_loc        in   16       sprite top row (sampled on frame_start)
//  z_loc        in   16       sprite depth (sampled on frame_start)
//  mirror_x     in   1        horizontal flip (sampled on frame_start)
//  pixel_x      in   16       current raster column
//  pixel_y      in   16       current raster row; increments by 1 per line
//  rom_addr     out  ADDR_W   registered ROM address
//  rom_data     in   COLOR_W  ROM data, valid ROM_LATENCY clocks after rom_addr
//  color        out  COLOR_W  sprite colour, 0 when not opaque
//  opaque       out  1        sprite covers this pixel (for layer mux)
//  zone         out  4        latched zone (LED debug)
// BEHAVIOUR
//  Reset: all registers 0; rom_addr=0, color=0, opaque=0, zone=0; armed=0 (no output until first frame_start).
//  Latch: on frame_start capture x/y/z/mirror; zone, SIZE=SPRITE_SIZE(zone), BASE=ROM_BASE(zone) registered same edge; armed<=1.
//   Mid-frame input changes ignored. frame_start coincident with line change: latch wins; new values used from next clock.
//  Zone: comparator chain on z_loc; z >= (NUM_ZONES-1)*ZONE_DEPTH -> last zone. SIZE = side length - 1 (default 69,53,43,36,31,27,24,22,20,18).
//  Hit: x_lat<=pixel_x<=x_lat+SIZE and y_lat<=pixel_y<=y_lat+SIZE; bounds computed 17-bit, no wrap; off-screen part simply never hits.
//  Row tracking (r_pixel_y register, row_base register):
//   row_next = (pixel_y==y_lat) ? BASE : (pixel_y!=r_pixel_y) ? row_base+SIZE+1 : row_base; row_base<=row_next each clock.
//  Column: col = pixel_x-x_lat, or SIZE-(pixel_x-x_lat) when mirror latched.
//  Stage 1: rom_addr <= hit ? row_next+col : rom_addr (held); hit delayed in shift reg of length ROM_LATENCY+1.
//  Output stage: opaque <= armed & hit_d & (rom_data!=TRANSP_KEY); color <= opaque_next ? rom_data : 0.
//  Latency: pixel on pixel_x/pixel_y at edge t -> color/opaque valid after edge t+1+ROM_LATENCY (default 2).
//  Reset mid-line: outputs 0 at once; pipeline flushed; idle until next frame_start.
// STRUCTURE
//  sprite_pkg: NUM_ZONES default, functions SPRITE_SIZE(zone), ROM_BASE(zone)
//   (prefix sums of (SIZE+1)^2: 0,4900,7816,9752,...), zone width constant.
//  Sub-module sprite_zone_decode: z_loc -> zone/SIZE/BASE, purely combinational; latching stays in top.
//  Top: latch regs, row tracker, address stage, hit delay line, output stage.
// TESTING (model ROM = addr echo, ROM_LATENCY=1; all other parameters at default)
//  x=100,y=50,z=0 latched; pixel (100,50) -> rom_addr 0 next clk; color=0x000000 (key), opaque 0 two clks later.
//  Same frame, pixel (101,51) -> rom_addr 71; opaque=1, color=71 two clks after input.
//  z=150 -> zone 1; pixel (100,50) -> rom_addr 4900; (154,50) no hit; z=5000 -> zone 9.
//  mirror_x=1, z=0; pixel (100,50) -> rom_addr 69; (169,50) -> rom_addr 0.
//  x_loc changed to 300 mid-frame -> hits stay at x=100 until next frame_start.
//  rst_n low during hit -> color=0, opaque=0, rom_addr=0 immediately; no opaque until next frame_start.

Source files
------------

// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared constants and zone lookup tables for the sprite scaler
package sprite_pkg;

  localparam int NUM_ZONES_DEF = 10;
  localparam int ZONE_W        = 4;
  localparam int SIZE_W        = 7;

  // Side length minus one for each pre-scaled bitmap, nearest zone first.
  function automatic logic [SIZE_W-1:0] SPRITE_SIZE(input logic [ZONE_W-1:0] zone);
    logic [SIZE_W-1:0] s;
    case (zone)
      4'd0:    s = 7'd69;
      4'd1:    s = 7'd53;
      4'd2:    s = 7'd43;
      4'd3:    s = 7'd36;
      4'd4:    s = 7'd31;
      4'd5:    s = 7'd27;
      4'd6:    s = 7'd24;
      4'd7:    s = 7'd22;
      4'd8:    s = 7'd20;
      default: s = 7'd18;
    endcase
    return s;
  endfunction

  // Start word of a zone's bitmap: bitmaps are packed back to back in one ROM.
  function automatic int ROM_BASE(input logic [ZONE_W-1:0] zone);
    int base;
    int side;
    base = 0;
    for (int i = 0; i < NUM_ZONES_DEF; i++) begin
      if (i < int'(zone)) begin
        side = int'(SPRITE_SIZE(ZONE_W'(i))) + 1;
        base = base + side * side;
      end
    end
    return base;
  endfunction

endpackage

// File: rtl/sprite_zone_decode.sv
// rtl/sprite_zone_decode.sv - combinational depth to zone/size/base decode
module sprite_zone_decode
  import sprite_pkg::*;
#(
  parameter int NUM_ZONES  = NUM_ZONES_DEF,
  parameter int ZONE_DEPTH = 100,
  parameter int ADDR_W     = 14
) (
  input  logic [15:0]       z_loc,
  output logic [ZONE_W-1:0] zone,
  output logic [SIZE_W-1:0] size,
  output logic [ADDR_W-1:0] base
);

  // Comparator chain: the last threshold crossed selects the zone, saturating at the far zone.
  always_comb begin
    zone = '0;
    for (int i = 1; i < NUM_ZONES; i++) begin
      if ({16'd0, z_loc} >= 32'(i * ZONE_DEPTH)) begin
        zone = ZONE_W'(i);
      end
    end
    size = SPRITE_SIZE(zone);
    base = ADDR_W'(ROM_BASE(zone));
  end

endmodule

// File: rtl/sprite_depth_scaler.sv
// rtl/sprite_depth_scaler.sv - depth-scaled sprite renderer with ROM address pipeline
module sprite_depth_scaler
  import sprite_pkg::*;
#(
  parameter int                 NUM_ZONES   = NUM_ZONES_DEF,
  parameter int                 ZONE_DEPTH  = 100,
  parameter int                 ADDR_W      = 14,
  parameter int                 COLOR_W     = 24,
  parameter int                 ROM_LATENCY = 1,
  parameter logic [COLOR_W-1:0] TRANSP_KEY  = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic [15:0]        x_loc,
  input  logic [15:0]        y_loc,
  input  logic [15:0]        z_loc,
  input  logic               mirror_x,
  input  logic [15:0]        pixel_x,
  input  logic [15:0]        pixel_y,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [COLOR_W-1:0] rom_data,
  output logic [COLOR_W-1:0] color,
  output logic               opaque,
  output logic [3:0]         zone
);

  logic [ZONE_W-1:0]  dec_zone;
  logic [SIZE_W-1:0]  dec_size;
  logic [ADDR_W-1:0]  dec_base;

  logic [15:0]        x_lat_q, x_lat_d;
  logic [15:0]        y_lat_q, y_lat_d;
  logic               mirror_q, mirror_d;
  logic [ZONE_W-1:0]  zone_q, zone_d;
  logic [SIZE_W-1:0]  size_q, size_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic               armed_q, armed_d;

  logic [15:0]        r_pixel_y_q, r_pixel_y_d;
  logic [ADDR_W-1:0]  row_base_q, row_base_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic [ROM_LATENCY:0] hit_sr_q, hit_sr_d;
  logic               opaque_q, opaque_d;
  logic [COLOR_W-1:0] color_q, color_d;

  logic [16:0]        x_end, y_end;
  logic               hit;
  logic [15:0]        dx;
  logic [ADDR_W-1:0]  col;
  logic [ADDR_W-1:0]  row_next;

  sprite_zone_decode #(
    .NUM_ZONES  (NUM_ZONES),
    .ZONE_DEPTH (ZONE_DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_zone_decode (
    .z_loc (z_loc),
    .zone  (dec_zone),
    .size  (dec_size),
    .base  (dec_base)
  );

  // Frame latch: sprite placement is frozen for the whole frame once frame_start is seen.
  always_comb begin
    x_lat_d  = x_lat_q;
    y_lat_d  = y_lat_q;
    mirror_d = mirror_q;
    zone_d   = zone_q;
    size_d   = size_q;
    base_d   = base_q;
    armed_d  = armed_q;
    if (frame_start) begin
      x_lat_d  = x_loc;
      y_lat_d  = y_loc;
      mirror_d = mirror_x;
      zone_d   = dec_zone;
      size_d   = dec_size;
      base_d   = dec_base;
      armed_d  = 1'b1;
    end
  end

  // Hit test, row tracking, address generation and output stage using this frame's latched values.
  always_comb begin
    x_end = {1'b0, x_lat_q} + {10'd0, size_q};
    y_end = {1'b0, y_lat_q} + {10'd0, size_q};
    hit   = armed_q &&
            (pixel_x >= x_lat_q) && ({1'b0, pixel_x} <= x_end) &&
            (pixel_y >= y_lat_q) && ({1'b0, pixel_y} <= y_end);

    dx  = pixel_x - x_lat_q;
    col = mirror_q ? (ADDR_W'(size_q) - ADDR_W'(dx)) : ADDR_W'(dx);

    if (pixel_y == y_lat_q) begin
      row_next = base_q;
    end else if (pixel_y != r_pixel_y_q) begin
      row_next = row_base_q + ADDR_W'(size_q) + ADDR_W'(1);
    end else begin
      row_next = row_base_q;
    end

    r_pixel_y_d = pixel_y;
    row_base_d  = row_next;
    rom_addr_d  = hit ? (row_next + col) : rom_addr_q;
    hit_sr_d    = {hit_sr_q[ROM_LATENCY-1:0], hit};

    opaque_d = armed_q && hit_sr_q[ROM_LATENCY] && (rom_data != TRANSP_KEY);
    color_d  = opaque_d ? rom_data : '0;
  end

  // State registers; reset clears everything and disarms until the next frame_start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_lat_q     <= '0;
      y_lat_q     <= '0;
      mirror_q    <= 1'b0;
      zone_q      <= '0;
      size_q      <= '0;
      base_q      <= '0;
      armed_q     <= 1'b0;
      r_pixel_y_q <= '0;
      row_base_q  <= '0;
      rom_addr_q  <= '0;
      hit_sr_q    <= '0;
      opaque_q    <= 1'b0;
      color_q     <= '0;
    end else begin
      x_lat_q     <= x_lat_d;
      y_lat_q     <= y_lat_d;
      mirror_q    <= mirror_d;
      zone_q      <= zone_d;
      size_q      <= size_d;
      base_q      <= base_d;
      armed_q     <= armed_d;
      r_pixel_y_q <= r_pixel_y_d;
      row_base_q  <= row_base_d;
      rom_addr_q  <= rom_addr_d;
      hit_sr_q    <= hit_sr_d;
      opaque_q    <= opaque_d;
      color_q     <= color_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign color    = color_q;
  assign opaque   = opaque_q;
  assign zone     = 4'(zone_q);

endmodule

// File: tb/tb_sprite_depth_scaler.sv
// tb/tb_sprite_depth_scaler.sv - directed self-checking bench for sprite_depth_scaler
module tb_sprite_depth_scaler;

  logic        clk;
  logic        rst_n;
  logic        frame_start;
  logic [15:0] x_loc, y_loc, z_loc;
  logic        mirror_x;
  logic [15:0] pixel_x, pixel_y;
  logic [13:0] rom_addr;
  logic [23:0] rom_data;
  logic [23:0] color;
  logic        opaque;
  logic [3:0]  zone;

  int n_tests = 0;
  int n_fail  = 0;

  sprite_depth_scaler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .x_loc       (x_loc),
    .y_loc       (y_loc),
    .z_loc       (z_loc),
    .mirror_x    (mirror_x),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .color       (color),
    .opaque      (opaque),
    .zone        (zone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Address-echo ROM with one clock of latency.
  always @(posedge clk) rom_data <= {10'd0, rom_addr};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic latch(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                       input logic m);
    x_loc       = x;
    y_loc       = y;
    z_loc       = z;
    mirror_x    = m;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  // Present a pixel and hold it; check the address one edge later and the output two edges after that.
  task automatic pix(input string tag, input logic [15:0] px, input logic [15:0] py,
                     input int exp_addr, input int exp_op, input int exp_col);
    pixel_x = px;
    pixel_y = py;
    step();
    check({tag, ".addr"}, 32'(rom_addr), 32'(exp_addr));
    step();
    step();
    check({tag, ".opaque"}, 32'(opaque), 32'(exp_op));
    check({tag, ".color"}, 32'(color), 32'(exp_col));
  endtask

  initial begin
    rst_n       = 1'b0;
    frame_start = 1'b0;
    x_loc       = '0;
    y_loc       = '0;
    z_loc       = '0;
    mirror_x    = 1'b0;
    pixel_x     = '0;
    pixel_y     = '0;
    step();
    step();
    check("rst.addr", 32'(rom_addr), 0);
    check("rst.color", 32'(color), 0);
    check("rst.opaque", 32'(opaque), 0);
    check("rst.zone", 32'(zone), 0);
    rst_n = 1'b1;

    // Not armed yet: pixel (0,0) lies inside the all-zero latch but must not render.
    pix("unarmed", 16'd0, 16'd0, 0, 0, 0);

    pixel_y = 16'd49;
    latch(16'd100, 16'd50, 16'd0, 1'b0);
    check("z0.zone", 32'(zone), 0);
    pix("z0.corner", 16'd100, 16'd50, 0, 0, 0);
    pix("z0.p101_51", 16'd101, 16'd51, 71, 1, 71);

    // Mid-frame placement change must be ignored.
    x_loc = 16'd300;
    pix("mid.p100_52", 16'd100, 16'd52, 140, 1, 140);
    pix("mid.p300_52", 16'd300, 16'd52, 140, 0, 0);

    latch(16'd100, 16'd50, 16'd150, 1'b0);
    check("z150.zone", 32'(zone), 1);
    pix("z1.corner", 16'd100, 16'd50, 4900, 1, 4900);
    pix("z1.p154", 16'd154, 16'd50, 4900, 0, 0);

    latch(16'd100, 16'd50, 16'd5000, 1'b0);
    check("z5000.zone", 32'(zone), 9);
    pix("z9.corner", 16'd100, 16'd50, 14524, 1, 14524);

    latch(16'd100, 16'd50, 16'd99, 1'b0);
    check("z99.zone", 32'(zone), 0);
    latch(16'd100, 16'd50, 16'd100, 1'b0);
    check("z100.zone", 32'(zone), 1);
    latch(16'd100, 16'd50, 16'd899, 1'b0);
    check("z899.zone", 32'(zone), 8);
    latch(16'd100, 16'd50, 16'd900, 1'b0);
    check("z900.zone", 32'(zone), 9);

    latch(16'd100, 16'd50, 16'd0, 1'b1);
    pix("mir.p100", 16'd100, 16'd50, 69, 1, 69);
    pix("mir.p169", 16'd169, 16'd50, 0, 0, 0);

    // Reset while the sprite is being drawn.
    latch(16'd100, 16'd50, 16'd0, 1'b0);
    pix("pre_rst.p102", 16'd102, 16'd50, 2, 1, 2);
    rst_n = 1'b0;
    #1;
    check("mid_rst.addr", 32'(rom_addr), 0);
    check("mid_rst.opaque", 32'(opaque), 0);
    check("mid_rst.color", 32'(color), 0);
    step();
    rst_n = 1'b1;
    step();
    step();
    step();
    check("post_rst.opaque", 32'(opaque), 0);
    check("post_rst.addr", 32'(rom_addr), 0);
    latch(16'd100, 16'd50, 16'd0, 1'b0);
    pix("rearm.p102", 16'd102, 16'd50, 2, 1, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
